// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter between writeback and multdiv
// Registered write port, starvation guard for md, and per-register pending scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_reg,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  chk_regA,
  input  logic [4:0]  chk_regB,
  output logic        hazard_A,
  output logic        hazard_B,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        issue_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pending_q, pending_d;
  logic             err_q, err_d;
  logic             md_force, gnt_wb, gnt_md;

  always_comb begin
    md_force = md_valid && (cnt_q == LIMIT);
    gnt_md   = md_valid && (md_force || !wb_valid);
    gnt_wb   = wb_valid && !md_force;
  end

  assign wb_ready = gnt_wb;
  assign md_ready = gnt_md;

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (!md_valid || gnt_md) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    // r0 grants are accepted but never strobe the regfile
    if (gnt_wb) begin
      we_d    = (wb_reg != 5'd0);
      wreg_d  = wb_reg;
      wdata_d = wb_data;
    end else if (gnt_md) begin
      we_d    = (md_reg != 5'd0);
      wreg_d  = md_reg;
      wdata_d = md_data;
    end
  end

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (gnt_md) begin
      pending_d[md_reg] = 1'b0;
    end
    // applied after the clear so a same-cycle issue wins
    if (md_issue && (md_issue_reg != 5'd0)) begin
      pending_d[md_issue_reg] = 1'b1;
      if (pending_q[md_issue_reg]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      cnt_q     <= '0;
      we_q      <= 1'b0;
      wreg_q    <= 5'd0;
      wdata_q   <= 32'd0;
      pending_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign hazard_A = (chk_regA != 5'd0) && (pending_q[chk_regA] || (we_q && (wreg_q == chk_regA)));
  assign hazard_B = (chk_regB != 5'd0) && (pending_q[chk_regB] || (we_q && (wreg_q == chk_regB)));

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign issue_err        = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  chk_regA, chk_regB;
  logic        hazard_A, hazard_B;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        issue_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .chk_regA(chk_regA), .chk_regB(chk_regB), .hazard_A(hazard_A), .hazard_B(hazard_B),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .issue_err(issue_err)
  );

  typedef struct {
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] mdat;
    logic        e_wrdy;
    logic        e_mrdy;
    logic        e_we;
    logic        chk_addr;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    md_issue = 1'b0; md_issue_reg = 5'd0;
  endtask

  task automatic edge_tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int wexp[6];
    int mexp[6];
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'h1234};
    vecs[3] = '{1'b1, 5'd10, 32'hA,        1'b1, 5'd11, 32'hB,    1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hB,    1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'hB};
    vecs[5] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h77,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};

    ctrl_reset = 1'b1;
    idle();
    chk_regA = 5'd0; chk_regB = 5'd0;
    edge_tick();
    edge_tick();
    check("rst_we", ctrl_writeEnable, 0);
    check("rst_reg", ctrl_writeReg, 0);
    check("rst_data", data_writeReg, 0);
    check("rst_err", issue_err, 0);
    ctrl_reset = 1'b0;
    edge_tick();

    for (int i = 0; i < 8; i++) begin
      wb_valid = vecs[i].wv; wb_reg = vecs[i].wr; wb_data = vecs[i].wd;
      md_valid = vecs[i].mv; md_reg = vecs[i].mr; md_data = vecs[i].mdat;
      #1;
      check($sformatf("v%0d_wb_ready", i), wb_ready, vecs[i].e_wrdy);
      check($sformatf("v%0d_md_ready", i), md_ready, vecs[i].e_mrdy);
      edge_tick();
      check($sformatf("v%0d_we", i), ctrl_writeEnable, vecs[i].e_we);
      if (vecs[i].chk_addr) begin
        check($sformatf("v%0d_reg", i), ctrl_writeReg, vecs[i].e_reg);
        check($sformatf("v%0d_data", i), data_writeReg, vecs[i].e_data);
      end
    end

    // single wb: in-flight hazard for exactly one cycle
    idle();
    edge_tick();
    chk_regA = 5'd5;
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    check("wb5_ready", wb_ready, 1);
    check("wb5_hazA_grant", hazard_A, 0);
    edge_tick();
    idle();
    #1;
    check("wb5_we", ctrl_writeEnable, 1);
    check("wb5_hazA_flight", hazard_A, 1);
    edge_tick();
    check("wb5_hazA_after", hazard_A, 0);

    // contention with both sources held: wb x4, md forced, wb again
    wexp = '{1, 1, 1, 1, 0, 1};
    mexp = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      wb_valid = 1'b1; wb_reg = 5'd13; wb_data = 32'h13;
      md_valid = 1'b1; md_reg = 5'd12; md_data = 32'h12;
      #1;
      check($sformatf("cont%0d_wb_ready", i), wb_ready, wexp[i][0]);
      check($sformatf("cont%0d_md_ready", i), md_ready, mexp[i][0]);
      edge_tick();
      check($sformatf("cont%0d_reg", i), ctrl_writeReg, (i == 4) ? 5'd12 : 5'd13);
    end
    idle();
    edge_tick();

    // scoreboard on reg 7
    chk_regA = 5'd0;
    chk_regB = 5'd7;
    md_issue = 1'b1; md_issue_reg = 5'd7;
    #1;
    check("sb7_issue_cycle", hazard_B, 0);
    edge_tick();
    idle();
    #1;
    check("sb7_pend1", hazard_B, 1);
    edge_tick();
    check("sb7_pend2", hazard_B, 1);
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h77;
    #1;
    check("sb7_md_ready", md_ready, 1);
    check("sb7_grant_cycle", hazard_B, 1);
    edge_tick();
    idle();
    #1;
    check("sb7_inflight", hazard_B, 1);
    edge_tick();
    check("sb7_clear", hazard_B, 0);

    // same-cycle issue and completion on reg 9, then re-issue
    chk_regB = 5'd0;
    chk_regA = 5'd9;
    md_issue = 1'b1; md_issue_reg = 5'd9;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h99;
    #1;
    check("r9_md_ready", md_ready, 1);
    edge_tick();
    idle();
    #1;
    check("r9_err_clean", issue_err, 0);
    check("r9_haz1", hazard_A, 1);
    edge_tick();
    check("r9_pending", hazard_A, 1);
    md_issue = 1'b1; md_issue_reg = 5'd9;
    edge_tick();
    idle();
    #1;
    check("r9_reissue_err", issue_err, 1);
    edge_tick();
    check("r9_err_sticky", issue_err, 1);

    // md_issue to r0 and hazard checks on r0
    chk_regA = 5'd0;
    chk_regB = 5'd0;
    md_issue = 1'b1; md_issue_reg = 5'd0;
    edge_tick();
    idle();
    #1;
    check("r0_hazA", hazard_A, 0);
    check("r0_hazB", hazard_B, 0);

    // reset in the middle of a write with a pending bit set
    chk_regA = 5'd4;
    chk_regB = 5'd6;
    md_issue = 1'b1; md_issue_reg = 5'd4;
    wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'h66;
    edge_tick();
    idle();
    #1;
    check("pre_rst_we", ctrl_writeEnable, 1);
    check("pre_rst_hazA", hazard_A, 1);
    check("pre_rst_hazB", hazard_B, 1);
    ctrl_reset = 1'b1;
    #1;
    check("mid_rst_we", ctrl_writeEnable, 0);
    check("mid_rst_reg", ctrl_writeReg, 0);
    check("mid_rst_data", data_writeReg, 0);
    check("mid_rst_err", issue_err, 0);
    check("mid_rst_hazA", hazard_A, 0);
    check("mid_rst_hazB", hazard_B, 0);
    #1;
    ctrl_reset = 1'b0;
    edge_tick();
    check("post_rst_hazA", hazard_A, 0);
    check("post_rst_we", ctrl_writeEnable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
